// File: rtl/axis_arb_pkg.sv
// Shared types and the rotate-priority helper for the frame-locked AXI-stream arbiter.
package axis_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Source index that sits 'off' slots after 'base' on a ring of m sources (0 < off <= m).
    function automatic int rr_next(input int base, input int off, input int m);
        int sum;
        sum = base + off;
        if (sum >= m) begin
            sum = sum - m;
        end
        return sum;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after ptr, wrapping; ptr itself has lowest priority.
module rr_pick
    import axis_arb_pkg::*;
#(
    parameter  int M   = 4,
    localparam int IDW = $clog2(M)
) (
    input  logic [M-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           any,
    output logic [IDW-1:0] idx
);

    logic [IDW-1:0] w_slot;

    // Scan farthest-to-nearest so the slot closest after ptr overwrites the others.
    always_comb begin
        any    = 1'b0;
        idx    = '0;
        w_slot = '0;
        for (int k = M; k >= 1; k--) begin
            w_slot = IDW'(rr_next(int'(ptr), k, M));
            if (req[w_slot]) begin
                any = 1'b1;
                idx = w_slot;
            end
        end
    end

endmodule

// File: rtl/axis_frame_arb.sv
// Round-robin frame-locked arbiter: M AXI-stream sources onto one registered output, 1 cycle grant, 1 cycle accept->m_vld.
// Backpressure: granted s_rdy = !m_vld | m_rdy, so a full output stalls the source with no loss; frames never interleave.
module axis_frame_arb
    import axis_arb_pkg::*;
#(
    parameter  int M     = 4,
    parameter  int DATAW = 64,
    parameter  int CNTW  = 16,
    localparam int IDW   = $clog2(M)
) (
    input  logic                      clk,
    input  logic                      s_rst_n,
    input  logic                      arb_en,
    input  logic [M-1:0][DATAW-1:0]   s_data,
    input  logic [M-1:0]              s_vld,
    input  logic [M-1:0]              s_last,
    output logic [M-1:0]              s_rdy,
    output logic [DATAW-1:0]          m_data,
    output logic                      m_vld,
    output logic                      m_last,
    input  logic                      m_rdy,
    output logic [IDW-1:0]            gnt_id,
    output logic                      busy,
    output logic [CNTW-1:0]           frame_cnt
);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   r_gnt;
    logic [IDW-1:0]   w_idx;
    logic             w_any;
    logic             w_gnt_rdy;
    logic             w_accept;
    logic             w_frame_end;
    logic [DATAW-1:0] r_m_data;
    logic             r_m_vld;
    logic             r_m_last;
    logic [CNTW-1:0]  r_frame_cnt;

    rr_pick #(.M(M)) u_rr_pick (
        .req (s_vld),
        .ptr (r_ptr),
        .any (w_any),
        .idx (w_idx)
    );

    // Ready is gated by reset so nothing handshakes while the block is being cleared.
    assign w_gnt_rdy   = s_rst_n && (r_state == LOCKED) && (!r_m_vld || m_rdy);
    assign w_accept    = w_gnt_rdy && s_vld[r_gnt];
    assign w_frame_end = w_accept && s_last[r_gnt];

    always_comb begin
        s_rdy        = '0;
        s_rdy[r_gnt] = w_gnt_rdy;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:   if (arb_en && w_any) w_state_nxt = LOCKED;
            LOCKED: if (w_frame_end)     w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            r_state     <= IDLE;
            r_ptr       <= IDW'(M - 1);
            r_gnt       <= '0;
            r_m_data    <= '0;
            r_m_vld     <= 1'b0;
            r_m_last    <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && arb_en && w_any) begin
                r_gnt <= w_idx;
            end
            if (w_frame_end) begin
                r_ptr <= r_gnt;
            end
            if (w_accept) begin
                r_m_data <= s_data[r_gnt];
                r_m_last <= s_last[r_gnt];
                r_m_vld  <= 1'b1;
            end else if (m_rdy) begin
                r_m_vld  <= 1'b0;
            end
            if (r_m_vld && m_rdy && r_m_last) begin
                r_frame_cnt <= r_frame_cnt + CNTW'(1);
            end
        end
    end

    assign m_data    = r_m_data;
    assign m_vld     = r_m_vld;
    assign m_last    = r_m_last;
    assign gnt_id    = r_gnt;
    assign busy      = (r_state == LOCKED);
    assign frame_cnt = r_frame_cnt;

endmodule

// File: doc/axis_frame_arb.md
Name: axis_frame_arb

Overview:
Round-robin, frame-locked arbiter that shares one AXI-stream sink among M stream sources, such as several axis_gen-style LFSR generators feeding one encoder input.
- Grant is held from the first beat of a frame until its last beat, so frames are never interleaved.
- Output is registered.
- Also provides a global arbitration enable and a completed-frame counter for the test harness.

Parameters:
M, 4, number of source ports (M >= 2)
DATAW, 64, data width of every stream
CNTW, 16, width of completed-frame counter
IDW, $clog2(M) (localparam), width of grant index

Ports:
clk  in  1  clock; all logic on rising edge
s_rst_n  in  1  reset, synchronous, active-low
arb_en  in  1  1 = new frames may be granted
s_data  in  M x DATAW  per-source data
s_vld  in  M  per-source valid
s_last  in  M  per-source end-of-frame
s_rdy  out  M  per-source ready (combinational)
m_data  out  DATAW  merged data (registered)
m_vld  out  1  merged valid (registered)
m_last  out  1  merged last (registered)
m_rdy  in  1  downstream ready
gnt_id  out  IDW  index of current/last granted source
busy  out  1  1 while in LOCKED
frame_cnt  out  CNTW  frames completed at output (wraps)

Behaviour:
- Reset (s_rst_n=0 at posedge) values:
  - state=IDLE; m_vld=0, m_last=0, m_data=0.
  - gnt_id=0; rr_ptr=M-1, so source 0 wins first.
  - frame_cnt=0; s_rdy=0 during reset.
  - Reset mid-frame abandons the frame; no flush, and the partial output beat is dropped.
- States:
  - IDLE: s_rdy all 0. If arb_en=1 and any s_vld=1, pick the first set s_vld scanning rr_ptr+1, rr_ptr+2, … modulo M. Then gnt_id<=winner and state<=LOCKED next cycle. If arb_en=0 or no request, stay in IDLE.
  - LOCKED: s_rdy[gnt_id] = !m_vld | m_rdy; all other s_rdy=0. A beat is accepted when s_vld[gnt_id] & s_rdy[gnt_id]. Accepting a beat with s_last[gnt_id]=1 sets state<=IDLE and rr_ptr<=gnt_id.
- arb_en=0 while LOCKED has no effect until the frame ends; it only blocks new grants.
- Output register:
  - On accept: m_data<=s_data[gnt_id], m_last<=s_last[gnt_id], m_vld<=1.
  - Else if m_rdy: m_vld<=0, while m_data/m_last hold.
  - Accept and drain in the same cycle give full throughput, 1 beat/cycle.
- Latency:
  - Request to grant: 1 cycle.
  - Grant to first acceptance: same cycle as LOCKED if the source is valid.
  - Accept to m_vld: 1 cycle.
  - Frame-to-frame turnaround: minimum 1 idle cycle (the IDLE arbitration cycle).
- Single-beat frame (s_vld & s_last on first beat): LOCKED for 1 cycle, then IDLE.
- m_rdy=0 stall: m_vld/m_data/m_last hold, s_rdy[gnt]=0, no loss or duplication.
- Source deasserts s_vld mid-frame: grant held indefinitely, no timeout.
- frame_cnt increments by 1 when m_vld & m_rdy & m_last, wrapping at 2^CNTW-1 -> 0.
- busy = (state==LOCKED). gnt_id holds its value in IDLE.

Decomposition:
- Package axis_arb_pkg holds:
  - typedef enum logic {IDLE, LOCKED} arb_state_t
  - the rotate-priority helper function
- Sub-module rr_pick #(M): combinational; inputs req[M], ptr[IDW]; outputs any, idx[IDW].
- Top holds the FSM, the output register and frame_cnt.

Test Plan:
- Reset, then s_vld=4'b0001, 3-beat frame (A1,A2,A3), m_rdy=1 -> gnt_id=0; m_data A1,A2,A3 on consecutive cycles; m_last with A3; frame_cnt=1.
- All four sources continuously request 2-beat frames -> grant order 0,1,2,3,0; frames never interleaved; 1 idle cycle between frames.
- Source 2 mid-frame, m_rdy low for 3 cycles -> m_vld/m_data held, s_rdy[2]=0 during stall, no beat lost or duplicated; resumes on m_rdy=1.
- arb_en=0 with s_vld=4'b1111 -> no grant and s_rdy=0. arb_en dropped mid-frame -> current frame completes, then IDLE with no new grant.
- Assert s_rst_n=0 during beat 2 of a 4-beat frame -> next cycle m_vld=0, state IDLE, rr_ptr=M-1, frame_cnt=0; source 0 granted first afterwards.
- With CNTW=4, send 17 single-beat frames -> frame_cnt reads 1 after wrap; each single-beat frame has m_last=1.
